// File: rtl/sub_mem_receiver.sv
// sub_mem_receiver: sub-core end of the main core's data-memory write broadcast.
// Buffers up to two broadcast writes per cycle in a FIFO and drains one per
// cycle into a local data-memory replica, while serving the sub-core's own
// load/store port and holding off reads that would return stale data.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   u_in_addr/u_in_din/u_in_we    upper-pipe broadcast write
//   l_in_addr/l_in_din/l_in_we    lower-pipe broadcast write
//   loc_req/loc_we/loc_addr/loc_din  local access request
//   loc_hold                      local request not accepted, hold it
//   loc_dout/loc_valid            read data, valid the cycle after a read
//   full                          fewer than 2 free FIFO slots (registered)
//   pending                       FIFO occupancy (registered)
//   overflow                      sticky, a broadcast write was dropped
module sub_mem_receiver #(
    parameter int DATA_MEM_DEPTH = 131072,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [31:0]                   u_in_addr,
    input  logic [31:0]                   u_in_din,
    input  logic                          u_in_we,
    input  logic [31:0]                   l_in_addr,
    input  logic [31:0]                   l_in_din,
    input  logic                          l_in_we,
    input  logic                          loc_req,
    input  logic                          loc_we,
    input  logic [31:0]                   loc_addr,
    input  logic [31:0]                   loc_din,
    output logic                          loc_hold,
    output logic [31:0]                   loc_dout,
    output logic                          loc_valid,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   pending,
    output logic                          overflow
);

    localparam int IW = $clog2(DATA_MEM_DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [31:0]   data;
    } entry_t;

    entry_t            fifo [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] slot_valid;
    logic [31:0]       mem [DATA_MEM_DEPTH];

    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     l_slot;

    logic [IW-1:0]     u_idx;
    logic [IW-1:0]     l_idx;
    logic [IW-1:0]     loc_idx;

    logic [CW-1:0]     free_slots;
    logic [CW-1:0]     n_in;
    logic [CW-1:0]     pending_next;
    logic              full_next;
    logic              u_acc;
    logic              l_acc;
    logic              drop;
    logic              loc_wr;
    logic              rd_req;
    logic              rd_acc;
    logic              drain;
    logic              fifo_hit;
    logic              hazard;
    entry_t            head;

    // Byte-offset and high address bits are always zero by contract.
    logic unused_bits;
    assign unused_bits = ^{u_in_addr[31:IW+2], u_in_addr[1:0],
                           l_in_addr[31:IW+2], l_in_addr[1:0],
                           loc_addr[31:IW+2], loc_addr[1:0]};

    assign u_idx   = u_in_addr[IW+1:2];
    assign l_idx   = l_in_addr[IW+1:2];
    assign loc_idx = loc_addr[IW+1:2];

    // Acceptance uses start-of-cycle occupancy; u claims a slot before l,
    // so with a single free slot the l write is the one dropped.
    assign free_slots = CW'(FIFO_DEPTH) - pending;
    assign u_acc      = u_in_we && (free_slots != '0);
    assign l_acc      = l_in_we && (free_slots > CW'(u_acc));
    assign drop       = (u_in_we && !u_acc) || (l_in_we && !l_acc);
    assign n_in       = CW'(u_acc) + CW'(l_acc);
    assign l_slot     = wr_ptr + PW'(u_acc);

    // A local write owns the single memory write port for the cycle.
    assign loc_wr = loc_req && loc_we;
    assign drain  = !rst && (pending != '0) && !loc_wr;
    assign head   = fifo[rd_ptr];

    assign pending_next = pending + n_in - CW'(drain);
    assign full_next    = (CW'(FIFO_DEPTH) - pending_next) < CW'(2);

    always_comb begin
        fifo_hit = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (slot_valid[i] && (fifo[i].idx == loc_idx)) begin
                fifo_hit = 1'b1;
            end
        end
    end

    // Any pending or in-flight broadcast to the read address makes the
    // replica stale for that word.
    assign hazard = fifo_hit
                 || (u_in_we && (u_idx == loc_idx))
                 || (l_in_we && (l_idx == loc_idx));

    assign rd_req   = loc_req && !loc_we;
    assign loc_hold = rd_req && hazard;
    assign rd_acc   = rd_req && !hazard && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            pending  <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (drain) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            wr_ptr  <= wr_ptr + PW'(n_in);
            pending <= pending_next;
            full    <= full_next;
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= '0;
        end else begin
            if (drain) begin
                slot_valid[rd_ptr] <= 1'b0;
            end
            if (u_acc) begin
                slot_valid[wr_ptr] <= 1'b1;
            end
            if (l_acc) begin
                slot_valid[l_slot] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (u_acc) begin
            fifo[wr_ptr] <= {u_idx, u_in_din};
        end
        if (l_acc) begin
            fifo[l_slot] <= {l_idx, l_in_din};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (loc_wr) begin
                mem[loc_idx] <= loc_din;
            end else if (drain) begin
                mem[head.idx] <= head.data;
            end
        end
    end

    // Read-first: sees the word as it was before this edge's drain write.
    always_ff @(posedge clk) begin
        if (rst) begin
            loc_valid <= 1'b0;
            loc_dout  <= '0;
        end else begin
            loc_valid <= rd_acc;
            if (rd_acc) begin
                loc_dout <= mem[loc_idx];
            end
        end
    end

endmodule
